// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC generator feeding a small in-order instruction queue
// Optional feature macro: FETCH_BYPASS_EN (forward a fetch straight to the deq outputs when the queue is empty)
module fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'hBFC00000)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trigger,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       branch_valid,
  input  logic [XLEN-1:0]            branch_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_instr,
  output logic [XLEN-1:0]            deq_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0]   NOP      = 32'h00000013;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Word-align any PC that gets loaded from outside the incrementer.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  // Program counter and queue bookkeeping
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Entry storage; contents are only meaningful where count says so
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pcp4_q  [DEPTH];

  logic            empty;
  logic            full;
  logic            flush;
  logic            fetch_slot;
  logic            pop;
  logic            fetch_go;
  logic            enq;
  logic            bypass_active;
  logic            bypass_taken;
  logic [XLEN-1:0] pc_plus4;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pc_plus4 = pc_q + XLEN'(4);

  // A redirect or branch kills everything in flight, including this cycle's fetch.
  assign flush      = redirect_valid | branch_valid;
  assign fetch_slot = trigger & ~flush;

  // Head leaves the queue whenever decode takes it; a flush in the same cycle wins anyway.
  assign pop = ~empty & deq_ready;

  // A full queue can still accept a fetch if the head drains in the same cycle.
  assign fetch_go = fetch_slot & (~full | pop);

`ifdef FETCH_BYPASS_EN
  assign bypass_active = empty & fetch_slot;
`else
  assign bypass_active = 1'b0;
`endif
  assign bypass_taken = bypass_active & deq_ready;

  // A bypassed instruction that decode accepts never needs a queue slot.
  assign enq = fetch_go & ~bypass_taken;

  assign imem_addr = pc_q;
  assign count     = count_q;

  // Head presentation: queue head, optional same-cycle forward, or NOP when nothing is valid
  always_comb begin
    deq_valid    = ~empty;
    deq_instr    = empty ? NOP : instr_q[rd_ptr_q];
    deq_pc_plus4 = empty ? '0 : pcp4_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    if (bypass_active) begin
      deq_valid    = 1'b1;
      deq_instr    = imem_rdata;
      deq_pc_plus4 = pc_plus4;
    end
`endif
  end

  // Next PC: redirect beats branch beats idle beats sequential fetch
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align4(redirect_pc);
    end else if (branch_valid) begin
      pc_d = align4(branch_pc);
    end else if (!trigger) begin
      pc_d = align4(RESET_VEC);
    end else if (fetch_go) begin
      pc_d = pc_plus4;
    end
  end

  // Next pointer and occupancy state; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(enq);
      count_d  = count_q + CW'(enq) - CW'(pop);
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= align4(RESET_VEC);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write port; no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pcp4_q[wr_ptr_q]  <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (vector table, directed corners, random vs queue model)
module tb_fetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        branch_valid;
  logic [31:0] branch_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc_plus4;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic        m_bypass;

  typedef struct {
    logic        rst;
    logic        tr;
    logic        rdy;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc4;
  } vec_t;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .branch_valid(branch_valid),
    .branch_pc(branch_pc),
    .deq_ready(deq_ready),
    .deq_valid(deq_valid),
    .deq_instr(deq_instr),
    .deq_pc_plus4(deq_pc_plus4),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h00500093;
    return {a[23:0], 8'h13};
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    trigger = 1'b0; redirect_valid = 1'b0; branch_valid = 1'b0; deq_ready = 1'b0;
    redirect_pc = '0; branch_pc = '0;
    #1;
    mq.delete();
    mpc = RV;
    check("rst_addr",  imem_addr, RV);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(deq_valid), 32'd0);
    check("rst_instr", deq_instr, NOP);
    check("rst_pcp4",  deq_pc_plus4, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs and compare outputs against the queue model.
  task automatic drive(input logic tr, input logic rv, input logic [31:0] rpc,
                       input logic bv, input logic [31:0] bpc, input logic rdy);
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    @(negedge clk);
    trigger = tr; redirect_valid = rv; redirect_pc = rpc;
    branch_valid = bv; branch_pc = bpc; deq_ready = rdy;
    #1;
    m_bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
    m_bypass = (mq.size() == 0) && tr && !rv && !bv;
`endif
    if (mq.size() > 0) begin
      ev = 1'b1; ei = mq[0].instr; ep = mq[0].pcp4;
    end else if (m_bypass) begin
      ev = 1'b1; ei = rom_word(mpc); ep = mpc + 32'd4;
    end else begin
      ev = 1'b0; ei = NOP; ep = 32'd0;
    end
    check("model_addr",  imem_addr, mpc);
    check("model_count", 32'(count), 32'(mq.size()));
    check("model_valid", 32'(deq_valid), 32'(ev));
    check("model_instr", deq_instr, ei);
    check("model_pcp4",  deq_pc_plus4, ep);
  endtask

  // Clock edge, then move the model forward using the inputs held this cycle.
  task automatic advance();
    @(posedge clk);
    if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else if (branch_valid) begin
      mq.delete();
      mpc = branch_pc & ~32'h3;
    end else begin
      if (deq_ready && mq.size() > 0) void'(mq.pop_front());
      if (!trigger) begin
        mpc = RV;
      end else if (m_bypass && deq_ready) begin
        mpc = mpc + 32'd4;
      end else if (mq.size() < DEPTH) begin
        mq.push_back('{rom_word(mpc), mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic tr, input logic rv, input logic [31:0] rpc,
                      input logic bv, input logic [31:0] bpc, input logic rdy);
    drive(tr, rv, rpc, bv, bpc, rdy);
    advance();
  endtask

  initial begin
    vec_t tbl[15];
    reset = 1'b1;
    trigger = 1'b0; redirect_valid = 1'b0; branch_valid = 1'b0; deq_ready = 1'b0;
    redirect_pc = '0; branch_pc = '0;
    m_bypass = 1'b0;
    mpc = RV;

    //         rst   tr    rdy   addr          cnt   v     instr          pc+4
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'hBFC00000, 3'd0, 1'b0, NOP,           32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00004, 3'd1, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'hBFC00000, 3'd0, 1'b0, NOP,           32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'hBFC00000, 3'd0, 1'b0, NOP,           32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00004, 3'd1, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00008, 3'd2, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0000C, 3'd3, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00010, 3'd4, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00010, 3'd4, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'hBFC00010, 3'd4, 1'b1, 32'h00500093, 32'hBFC00004};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'hBFC00014, 3'd4, 1'b1, 32'hC0000413, 32'hBFC00008};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'hBFC00000, 3'd3, 1'b1, 32'hC0000813, 32'hBFC0000C};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'hBFC00000, 3'd2, 1'b1, 32'hC0000C13, 32'hBFC00010};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'hBFC00000, 3'd1, 1'b1, 32'hC0001013, 32'hBFC00014};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'hBFC00000, 3'd0, 1'b0, NOP,           32'h0};

    apply_reset();

`ifndef FETCH_BYPASS_EN
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) apply_reset();
      drive(tbl[i].tr, 1'b0, 32'h0, 1'b0, 32'h0, tbl[i].rdy);
      check($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].addr);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_valid", i), 32'(deq_valid), 32'(tbl[i].v));
      check($sformatf("vec%0d_instr", i), deq_instr, tbl[i].ins);
      check($sformatf("vec%0d_pcp4", i),  deq_pc_plus4, tbl[i].pc4);
      advance();
    end
`endif

    // Redirect and branch in the same cycle with three entries queued: redirect wins
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'hBFC00100, 1'b1, 32'hBFC00200, 1'b0);
    check("pre_redirect_count", 32'(count), 32'd3);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("redirect_count", 32'(count), 32'd0);
    check("redirect_addr", imem_addr, 32'hBFC00100);
    check("redirect_valid_out", 32'(deq_valid), 32'd0);
    advance();

    // Branch to an unaligned target: low bits dropped, queue flushed
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC00042, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("branch_addr", imem_addr, 32'hBFC00040);
    check("branch_count", 32'(count), 32'd0);
    advance();

    // Empty queue with a fetch: same-cycle forward only when the bypass is built in
    apply_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_BYPASS_EN
    check("bypass_valid", 32'(deq_valid), 32'd1);
    check("bypass_instr", deq_instr, 32'h00500093);
    check("bypass_pcp4", deq_pc_plus4, 32'hBFC00004);
`else
    check("nobypass_valid", 32'(deq_valid), 32'd0);
    check("nobypass_instr", deq_instr, NOP);
`endif
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_BYPASS_EN
    check("bypass_not_enqueued", 32'(count), 32'd0);
`else
    check("first_fetch_enqueued", 32'(count), 32'd1);
`endif
    advance();

    // Randomized traffic against the model, with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 9) != 0,
             $urandom_range(0, 29) == 0, {16'hBFC0, 16'($urandom)},
             $urandom_range(0, 19) == 0, {16'hBFC0, 16'($urandom)},
             $urandom_range(0, 2) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
